// File: rtl/snake_pkg.sv
// Shared definitions for the snake display blocks.
// - MATRIX_ROWS / MATRIX_COLS: default LED matrix geometry.
// - scan_state_e: scan-decoder FSM encoding (S_IDLE, S_COUNT, S_HOLD).
// - onehot_low_index(): classifies an active-low cathode vector, returning
//   {valid, illegal, index}.
package snake_pkg;

    localparam int unsigned MATRIX_ROWS = 8;
    localparam int unsigned MATRIX_COLS = 8;
    localparam int unsigned ROW_IDX_W   = $clog2(MATRIX_ROWS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_HOLD  = 2'd2
    } scan_state_e;

    typedef struct packed {
        logic                 valid;    // exactly one cathode low
        logic                 illegal;  // two or more cathodes low
        logic [ROW_IDX_W-1:0] index;    // position of the low cathode when valid
    } onehot_info_t;

    function automatic onehot_info_t onehot_low_index(input logic [MATRIX_ROWS-1:0] cathode);
        onehot_info_t info;
        int unsigned  zeros;
        info  = '0;
        zeros = 0;
        for (int i = 0; i < int'(MATRIX_ROWS); i++) begin
            if (!cathode[i]) begin
                zeros++;
                info.index = ROW_IDX_W'(i);
            end
        end
        info.valid   = (zeros == 1);
        info.illegal = (zeros > 1);
        return info;
    endfunction

endpackage

// File: rtl/led_scan_decoder_if.sv
// Scan input / frame output bundle of the LED scan decoder.
// - in_row_cathode  : row select, active-low.
// - in_column_anode : column data, active-high.
// - in_frame_ready  : consumer accepts out_frame.
// - out_frame       : reconstructed frame, bit r*COLS+c = LED (r,c).
// - out_frame_valid : out_frame holds an unconsumed frame.
// - out_rows_seen   : rows captured in the frame being assembled.
// - out_overrun     : sticky, a completed frame replaced an unconsumed one.
// - out_illegal     : sticky, a sample had more than one cathode low.
// Modport master drives the scan (display side / bench), slave is the decoder.
interface led_scan_decoder_if
    import snake_pkg::*;
#(
    parameter int unsigned ROWS = MATRIX_ROWS,
    parameter int unsigned COLS = MATRIX_COLS
);
    logic [ROWS-1:0]      in_row_cathode;
    logic [COLS-1:0]      in_column_anode;
    logic                 in_frame_ready;
    logic [ROWS*COLS-1:0] out_frame;
    logic                 out_frame_valid;
    logic [ROWS-1:0]      out_rows_seen;
    logic                 out_overrun;
    logic                 out_illegal;

    modport master (
        output in_row_cathode, in_column_anode, in_frame_ready,
        input  out_frame, out_frame_valid, out_rows_seen, out_overrun, out_illegal
    );

    modport slave (
        input  in_row_cathode, in_column_anode, in_frame_ready,
        output out_frame, out_frame_valid, out_rows_seen, out_overrun, out_illegal
    );
endinterface

// File: rtl/led_scan_decoder_row_onehot_check.sv
// Combinational cathode classifier.
// - cathode     : active-low row select (ROWS bits, ROWS <= MATRIX_ROWS).
// - row_valid   : exactly one cathode low.
// - row_illegal : two or more cathodes low.
// - row_index   : position of the low cathode (meaningful when row_valid).
module row_onehot_check
    import snake_pkg::*;
#(
    parameter int unsigned ROWS  = MATRIX_ROWS,
    parameter int unsigned IDX_W = $clog2(ROWS)
) (
    input  logic [ROWS-1:0]  cathode,
    output logic             row_valid,
    output logic             row_illegal,
    output logic [IDX_W-1:0] row_index
);
    logic [MATRIX_ROWS-1:0] padded;
    onehot_info_t           info;

    // Unused upper cathodes read as inactive (high).
    always_comb begin
        padded             = '1;
        padded[ROWS-1:0]   = cathode;
        info               = onehot_low_index(padded);
        row_valid          = info.valid;
        row_illegal        = info.illegal;
        row_index          = info.index[IDX_W-1:0];
    end
endmodule

// File: rtl/led_scan_decoder.sv
// Rebuilds the 64-bit LED frame from the multiplexed row/column scan.
// - in_clka      : clock, rising edge.
// - in_restart_n : asynchronous active-low reset.
// - bus          : scan inputs, frame handshake and sticky flags (slave side).
// A row is accepted once its {row, anodes} pattern has been stable for
// STABLE_CYCLES samples; a frame is published the cycle after every row
// has been seen at least once.
module led_scan_decoder
    import snake_pkg::*;
#(
    parameter int unsigned ROWS          = MATRIX_ROWS,
    parameter int unsigned COLS          = MATRIX_COLS,
    parameter int unsigned STABLE_CYCLES = 2
) (
    input logic                in_clka,
    input logic                in_restart_n,
    led_scan_decoder_if.slave  bus
);
    localparam int unsigned IDX_W = $clog2(ROWS);
    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic SINGLE = (STABLE_CYCLES == 1);

    logic                 row_valid, row_illegal;
    logic [IDX_W-1:0]     row_index;
    scan_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;
    logic [IDX_W-1:0]     prev_row_q;
    logic [COLS-1:0]      prev_anode_q;
    logic                 same_pat, accept, frame_done;
    logic [ROWS*COLS-1:0] shadow_q, shadow_d, frame_q;
    logic [ROWS-1:0]      rows_seen_q, rows_seen_d;
    logic                 valid_q, overrun_q, illegal_q;

    row_onehot_check #(
        .ROWS  (ROWS),
        .IDX_W (IDX_W)
    ) u_check (
        .cathode     (bus.in_row_cathode),
        .row_valid   (row_valid),
        .row_illegal (row_illegal),
        .row_index   (row_index)
    );

    assign same_pat   = (row_index == prev_row_q) && (bus.in_column_anode == prev_anode_q);
    assign cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    assign frame_done = &rows_seen_q;

    // FSM: state register
    always_ff @(posedge in_clka or negedge in_restart_n) begin
        if (!in_restart_n) state_q <= S_IDLE;
        else               state_q <= state_d;
    end

    // FSM: next state (illegal samples have row_valid=0, so they act as blank)
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (row_valid) state_d = SINGLE ? S_HOLD : S_COUNT;
            S_COUNT: begin
                if (!row_valid)                      state_d = S_IDLE;
                else if (same_pat && cnt_inc == CNT_MAX) state_d = S_HOLD;
                else if (!same_pat && SINGLE)        state_d = S_HOLD;
            end
            S_HOLD: begin
                if (!row_valid)     state_d = S_IDLE;
                else if (!same_pat) state_d = SINGLE ? S_HOLD : S_COUNT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs (stability count and row accept strobe)
    always_comb begin
        cnt_d  = cnt_q;
        accept = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cnt_d  = row_valid ? CNT_ONE : '0;
                accept = row_valid && SINGLE;
            end
            S_COUNT: begin
                if (!row_valid) begin
                    cnt_d = '0;
                end else if (same_pat) begin
                    cnt_d  = cnt_inc;
                    accept = (cnt_inc == CNT_MAX);
                end else begin
                    cnt_d  = CNT_ONE;
                    accept = SINGLE;
                end
            end
            S_HOLD: begin
                // A long dwell on one pattern is accepted only once.
                if (!row_valid) begin
                    cnt_d = '0;
                end else if (!same_pat) begin
                    cnt_d  = CNT_ONE;
                    accept = SINGLE;
                end
            end
            default: cnt_d = '0;
        endcase
    end

    // Shadow frame and row bookkeeping; a row accepted in the completion
    // cycle starts the next frame's rows_seen.
    always_comb begin
        shadow_d    = shadow_q;
        rows_seen_d = frame_done ? '0 : rows_seen_q;
        if (accept) begin
            shadow_d[row_index*COLS +: COLS] = bus.in_column_anode;
            rows_seen_d[row_index]           = 1'b1;
        end
    end

    always_ff @(posedge in_clka or negedge in_restart_n) begin
        if (!in_restart_n) begin
            cnt_q        <= '0;
            prev_row_q   <= '0;
            prev_anode_q <= '0;
            shadow_q     <= '0;
            rows_seen_q  <= '0;
            frame_q      <= '0;
            valid_q      <= 1'b0;
            overrun_q    <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            prev_row_q   <= row_index;
            prev_anode_q <= bus.in_column_anode;
            shadow_q     <= shadow_d;
            rows_seen_q  <= rows_seen_d;
            illegal_q    <= illegal_q | row_illegal;
            if (frame_done) begin
                // Newer frame wins; flag it only if the old one was not taken now.
                frame_q <= shadow_q;
                valid_q <= 1'b1;
                if (valid_q && !bus.in_frame_ready) overrun_q <= 1'b1;
            end else if (bus.in_frame_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_frame       = frame_q;
    assign bus.out_frame_valid = valid_q;
    assign bus.out_rows_seen   = rows_seen_q;
    assign bus.out_overrun     = overrun_q;
    assign bus.out_illegal     = illegal_q;

endmodule

// File: tb/tb_led_scan_decoder.sv
// Directed bench for led_scan_decoder (8x8, STABLE_CYCLES=2).
module tb_led_scan_decoder;
    import snake_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fails;

    led_scan_decoder_if #(.ROWS(8), .COLS(8)) bus ();

    led_scan_decoder #(
        .ROWS          (8),
        .COLS          (8),
        .STABLE_CYCLES (2)
    ) dut (
        .in_clka      (clk),
        .in_restart_n (rst_n),
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one sample for n cycles; returns 1 time unit after the last edge.
    task automatic drive(input logic [7:0] cath, input logic [7:0] an, input int n);
        bus.in_row_cathode  = cath;
        bus.in_column_anode = an;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scan_row(input int r, input logic [7:0] an);
        logic [7:0] sel;
        sel = 8'h01 << r;
        drive(~sel, an, 2);
    endtask

    task automatic blank(input int n);
        drive(8'hFF, 8'h00, n);
    endtask

    int order[9] = '{7, 0, 5, 2, 6, 1, 5, 4, 3};

    initial begin
        logic [7:0] an;
        n_checks = 0;
        n_fails  = 0;
        rst_n    = 1'b0;
        bus.in_row_cathode  = 8'hFF;
        bus.in_column_anode = 8'h00;
        bus.in_frame_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_frame",   bus.out_frame,             64'h0);
        check("rst_valid",   64'(bus.out_frame_valid),  64'h0);
        check("rst_rows",    64'(bus.out_rows_seen),    64'h0);
        check("rst_overrun", 64'(bus.out_overrun),      64'h0);
        check("rst_illegal", 64'(bus.out_illegal),      64'h0);
        rst_n = 1'b1;
        blank(1);

        // In-order scan, diagonal pattern, consumer always ready
        bus.in_frame_ready = 1'b1;
        for (int r = 0; r < 8; r++) begin
            an = 8'h01 << r;
            scan_row(r, an);
        end
        check("t1_rows_full", 64'(bus.out_rows_seen), 64'hFF);
        blank(1);
        check("t1_valid",    64'(bus.out_frame_valid), 64'h1);
        check("t1_frame",    bus.out_frame,            64'h8040201008040201);
        check("t1_rows_clr", 64'(bus.out_rows_seen),   64'h0);
        blank(1);
        check("t1_pulse_end", 64'(bus.out_frame_valid), 64'h0);
        check("t1_overrun",   64'(bus.out_overrun),     64'h0);
        check("t1_illegal",   64'(bus.out_illegal),     64'h0);

        // Single-cycle row is not stable enough
        bus.in_frame_ready = 1'b0;
        drive(8'hF7, 8'hFF, 1);
        blank(2);
        check("t2_row3_skip", 64'(bus.out_rows_seen),   64'h0);
        check("t2_no_valid",  64'(bus.out_frame_valid), 64'h0);

        // Out-of-order scan, row 5 re-scanned with new data
        for (int i = 0; i < 9; i++) begin
            if (i == 6) an = 8'hAA;
            else        an = {order[i][3:0], order[i][3:0]};
            scan_row(order[i], an);
            if (i == 7) check("t3_rows_no3", 64'(bus.out_rows_seen), 64'hF7);
        end
        check("t3_rows_full", 64'(bus.out_rows_seen), 64'hFF);
        blank(1);
        check("t3_valid", 64'(bus.out_frame_valid), 64'h1);
        check("t3_frame", bus.out_frame,            64'h7766AA4433221100);
        blank(2);
        check("t3_hold_valid", 64'(bus.out_frame_valid), 64'h1);
        check("t3_hold_frame", bus.out_frame,            64'h7766AA4433221100);
        bus.in_frame_ready = 1'b1;
        blank(1);
        bus.in_frame_ready = 1'b0;
        check("t3_consumed",  64'(bus.out_frame_valid), 64'h0);
        check("t3_overrun",   64'(bus.out_overrun),     64'h0);

        // Two cathodes low
        drive(8'hF3, 8'h5A, 2);
        check("t4_illegal",   64'(bus.out_illegal),   64'h1);
        check("t4_rows",      64'(bus.out_rows_seen), 64'h0);
        check("t4_state",     64'(dut.state_q),       64'(S_IDLE));
        blank(2);
        check("t4_sticky",    64'(bus.out_illegal),   64'h1);

        // Two frames with nobody consuming
        for (int r = 0; r < 8; r++) scan_row(r, 8'(r));
        blank(1);
        check("t5_first_valid",   64'(bus.out_frame_valid), 64'h1);
        check("t5_first_frame",   bus.out_frame,            64'h0706050403020100);
        check("t5_first_overrun", 64'(bus.out_overrun),     64'h0);
        for (int r = 0; r < 8; r++) scan_row(r, 8'hC0 | 8'(r));
        blank(1);
        check("t5_overrun", 64'(bus.out_overrun),     64'h1);
        check("t5_frame",   bus.out_frame,            64'hC7C6C5C4C3C2C1C0);
        check("t5_valid",   64'(bus.out_frame_valid), 64'h1);
        bus.in_frame_ready = 1'b1;
        blank(1);
        bus.in_frame_ready = 1'b0;
        check("t5_drop",    64'(bus.out_frame_valid), 64'h0);
        check("t5_ovr_sticky", 64'(bus.out_overrun),  64'h1);

        // Asynchronous reset in the middle of a scan
        for (int r = 0; r < 4; r++) scan_row(r, 8'h3C);
        check("t6_partial", 64'(bus.out_rows_seen), 64'h0F);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_frame",   bus.out_frame,            64'h0);
        check("t6_rst_valid",   64'(bus.out_frame_valid), 64'h0);
        check("t6_rst_rows",    64'(bus.out_rows_seen),   64'h0);
        check("t6_rst_overrun", 64'(bus.out_overrun),     64'h0);
        check("t6_rst_illegal", 64'(bus.out_illegal),     64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        blank(1);
        for (int r = 0; r < 8; r++) begin
            an = 8'h80 >> r;
            scan_row(r, an);
        end
        blank(1);
        check("t6_valid",   64'(bus.out_frame_valid), 64'h1);
        check("t6_frame",   bus.out_frame,            64'h0102040810204080);
        check("t6_overrun", 64'(bus.out_overrun),     64'h0);
        check("t6_illegal", 64'(bus.out_illegal),     64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/led_scan_decoder.md
Name: led_scan_decoder

Overview:
- Receives the multiplexed LED-matrix drive (row cathodes, column anodes) that the snake top emits and rebuilds the 64-bit frame it represents.
- Inverse of the display multiplexer: it reads the scan instead of writing it.
- Used in-system for self-check/loopback, and by benches to compare against out_led_array_flat.
- Presents complete frames over a valid/ready handshake, with sticky error flags.

Parameters:
- ROWS, 8, number of matrix rows (cathode width).
- COLS, 8, number of matrix columns (anode width).
- STABLE_CYCLES, 2, consecutive identical samples needed before a row is accepted (>=1).

Ports:
- in_clka  input  1  sole clock; all state updates on rising edge.
- in_restart_n  input  1  asynchronous active-low reset.
- in_row_cathode  input  ROWS  row select, active-low; bit r low = row r driven.
- in_column_anode  input  COLS  column data, active-high; bit c high = LED (r,c) lit.
- in_frame_ready  input  1  consumer accepts out_frame when high with out_frame_valid.
- out_frame  output  ROWS*COLS  reconstructed frame; bit r*COLS+c = LED (r,c), same layout as out_led_array_flat.
- out_frame_valid  output  1  out_frame holds an unconsumed frame.
- out_rows_seen  output  ROWS  rows captured in the frame being assembled.
- out_overrun  output  1  sticky; a completed frame was dropped while the previous one was unconsumed.
- out_illegal  output  1  sticky; a sample had more than one cathode low.

Behaviour:
- Reset (async, in_restart_n=0):
  - out_frame=0, out_frame_valid=0, out_rows_seen=0, out_overrun=0, out_illegal=0.
  - Shadow frame=0, stability count=0, FSM=S_IDLE.
  - Reset mid-frame discards the partial frame and any pending valid frame.
- Sample classification, each cycle:
  - VALID: exactly one cathode bit is 0. Row index = position of that 0.
  - BLANK: all cathode bits are 1.
  - ILLEGAL: two or more cathode bits are 0. Sets out_illegal in the next cycle. Treated as BLANK for capture.
- Pattern = {row index, in_column_anode}. Both are registered each cycle for comparison.
- FSM:
  - S_IDLE:
    - VALID -> S_COUNT, count=1.
    - If STABLE_CYCLES==1, accept the row immediately and go to S_HOLD.
  - S_COUNT:
    - Same VALID pattern -> count+1. When count reaches STABLE_CYCLES: accept the row, go to S_HOLD.
    - Different VALID pattern -> restart, count=1, stay in S_COUNT.
    - BLANK/ILLEGAL -> S_IDLE.
  - S_HOLD:
    - Same pattern -> stay. No re-accept, so a long dwell counts once.
    - Different VALID pattern -> S_COUNT, count=1.
    - BLANK/ILLEGAL -> S_IDLE.
- Accept row r:
  - shadow[r*COLS +: COLS] <= anodes; out_rows_seen[r] <= 1.
  - Re-accepting a row already seen overwrites that shadow slice. It does not advance completion.
- Frame completion:
  - The cycle after out_rows_seen becomes all-ones (including the row just accepted): copy shadow to out_frame, set out_frame_valid, clear out_rows_seen.
  - Shadow is retained, not cleared.
  - Completion does not depend on scan order.
- Handshake:
  - out_frame_valid stays high and out_frame stays stable until a cycle with in_frame_ready=1.
  - Valid clears the following cycle unless a new frame completes in that same cycle. In that case out_frame updates and valid stays 1, with no overrun.
  - New frame completes while valid=1 and ready=0: out_frame is replaced by the newer frame, valid stays 1, out_overrun set.
- Counter width: clog2(STABLE_CYCLES+1). Saturates and never wraps.

Decomposition:
- Shared package snake_pkg:
  - MATRIX_ROWS=8, MATRIX_COLS=8.
  - Scan-decoder state encoding S_IDLE/S_COUNT/S_HOLD (2 bits).
  - Function onehot_low_index returning {valid, illegal, index}.
- One natural sub-module: row_onehot_check (combinational cathode classifier: count zeros, encode index). Everything else stays in led_scan_decoder.

Test Plan:
- Reset, then scan rows 0..7 in order, each held 2 cycles. Anodes = row r gets 8'h01<<r. -> One valid pulse, out_frame=64'h8040201008040201, out_rows_seen back to 0, no flags.
- Row 3 held 1 cycle only (STABLE_CYCLES=2), anodes 8'hFF -> row 3 not captured; out_rows_seen[3]=0.
- Scan order 7,0,5,2,6,1,4,3, with row 5 repeated later carrying 8'hAA before completion -> frame completes on the eighth distinct row; the row-5 slice is 8'hAA.
- Cathode 8'b1111_0011 for 2 cycles -> out_illegal=1 (sticky), no row captured, FSM in S_IDLE.
- Hold in_frame_ready=0 across two full scans -> out_overrun=1, out_frame = second frame. Raise ready for 1 cycle -> valid drops next cycle.
- Assert in_restart_n=0 mid-scan after 4 rows -> all outputs 0 immediately. A subsequent full scan completes normally.
